// File: rtl/flit_fifo_reader.sv
// Show-ahead FIFO consumer: 2-entry registered output buffer, packet framing, stats.
// Optional stall counter enabled by defining FLIT_READER_STATS_EN.
module flit_fifo_reader #(
  parameter int DSIZE       = 4,
  parameter int MAX_PKT_LEN = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [DSIZE-1:0] fifo_item,
  output logic             fifo_read,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_head,
  output logic [CNT_W-1:0] pkt_count,
  output logic             pkt_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic {HEAD, BODY} state_t;

  logic [1:0]       cnt;
  logic [DSIZE-1:0] main_q, skid_q;
  logic             xfer;
  state_t           state;
  logic [LEN_W-1:0] len, len_inc;
  logic             tail;

  // Pop decision uses only registered occupancy, never out_ready.
  assign fifo_read = reset && !fifo_empty && (cnt < 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = main_q;
  assign xfer      = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 2'd0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case ({fifo_read, xfer})
        2'b10: begin
          if (cnt == 2'd0) main_q <= fifo_item;
          else             skid_q <= fifo_item;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd2) main_q <= skid_q;
          cnt <= cnt - 2'd1;
        end
        // Pop with transfer only happens at count 1: new flit replaces main.
        2'b11:   main_q <= fifo_item;
        default: ;
      endcase
    end
  end

  // len is held at 0 while in HEAD, so len+1 is the packet length after this transfer.
  assign tail     = main_q[DSIZE-1];
  assign len_inc  = len + LEN_W'(1);
  assign out_head = out_valid && (state == HEAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HEAD;
      len       <= '0;
      pkt_count <= '0;
      pkt_err   <= 1'b0;
    end else if (xfer) begin
      if (tail) begin
        pkt_count <= pkt_count + CNT_W'(1);
        state     <= HEAD;
        len       <= '0;
      end else if (len_inc == LEN_W'(MAX_PKT_LEN)) begin
        pkt_err <= 1'b1;
        state   <= HEAD;
        len     <= '0;
      end else begin
        state <= BODY;
        len   <= len_inc;
      end
    end
  end

`ifdef FLIT_READER_STATS_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_q <= '0;
    else if (out_valid && !out_ready && (stall_q != '1))
      stall_q <= stall_q + CNT_W'(1);
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule
